// File: rtl/pdp_mem_arbiter.sv
// rtl/pdp_mem_arbiter.sv - single-port PDP-8 memory arbiter between ifetch and EXEC with bus locking
// Optional build macro PDP_ARB_RR_EN selects round-robin IDLE arbitration instead of fixed EXEC priority.
module pdp_mem_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 12,
   parameter int MAX_WAIT   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_rd_req,
   input  logic [ADDR_WIDTH-1:0] fetch_rd_addr,
   output logic                  fetch_rd_gnt,
   output logic                  fetch_rd_valid,
   output logic [DATA_WIDTH-1:0] fetch_rd_data,
   input  logic                  exec_rd_req,
   input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
   input  logic                  exec_wr_req,
   input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
   input  logic [DATA_WIDTH-1:0] exec_wr_data,
   input  logic                  exec_lock,
   output logic                  exec_rd_gnt,
   output logic                  exec_wr_gnt,
   output logic                  exec_rd_valid,
   output logic [DATA_WIDTH-1:0] exec_rd_data,
   output logic                  mem_rd_req,
   output logic                  mem_wr_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

   typedef enum logic {
      S_IDLE,
      S_LOCKED
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
   logic                  fetch_rd_gnt_q, fetch_rd_gnt_d;
   logic                  exec_rd_gnt_q, exec_rd_gnt_d;
   logic                  exec_wr_gnt_q, exec_wr_gnt_d;
   logic                  mem_rd_req_q, mem_rd_req_d;
   logic                  mem_wr_req_q, mem_wr_req_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
   logic                  rd_owner_exec_q, rd_owner_exec_d;
   logic                  fetch_rd_valid_q, fetch_rd_valid_d;
   logic [DATA_WIDTH-1:0] fetch_rd_data_q, fetch_rd_data_d;
   logic                  exec_rd_valid_q, exec_rd_valid_d;
   logic [DATA_WIDTH-1:0] exec_rd_data_q, exec_rd_data_d;
`ifdef PDP_ARB_RR_EN
   logic                  last_fetch_q, last_fetch_d;
`endif

   logic exec_pend;
   logic locked_hold;
   logic grant_exec;
   logic grant_fetch;
   logic do_exec_wr;
   logic do_exec_rd;

   always_comb begin
      exec_pend   = exec_wr_req | exec_rd_req;
      // LOCKED only holds while exec_lock stays high; a sampled 0 arbitrates as IDLE at once
      locked_hold = (state_q == S_LOCKED) && exec_lock;
      grant_exec  = 1'b0;
      grant_fetch = 1'b0;
      if (locked_hold) begin
         grant_exec = exec_pend;
      end else begin
`ifdef PDP_ARB_RR_EN
         if (exec_pend && fetch_rd_req) begin
            grant_fetch = ~last_fetch_q;
            grant_exec  = last_fetch_q;
         end else begin
            grant_exec  = exec_pend;
            grant_fetch = fetch_rd_req;
         end
`else
         if (fetch_rd_req && (!exec_pend || (wait_cnt_q == WAIT_LIMIT))) begin
            grant_fetch = 1'b1;
         end else begin
            grant_exec = exec_pend;
         end
`endif
      end
      do_exec_wr = grant_exec & exec_wr_req;
      do_exec_rd = grant_exec & ~exec_wr_req;
   end

   always_comb begin
      state_d = S_IDLE;
      if ((grant_exec && exec_lock) || locked_hold) begin
         state_d = S_LOCKED;
      end

      wait_cnt_d = wait_cnt_q;
      if (!locked_hold) begin
         if (grant_fetch) begin
            wait_cnt_d = '0;
         end else if (fetch_rd_req && (wait_cnt_q != WAIT_LIMIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
         end
      end

`ifdef PDP_ARB_RR_EN
      last_fetch_d = last_fetch_q;
      if (grant_fetch) begin
         last_fetch_d = 1'b1;
      end else if (grant_exec) begin
         last_fetch_d = 1'b0;
      end
`endif

      fetch_rd_gnt_d  = grant_fetch;
      exec_rd_gnt_d   = do_exec_rd;
      exec_wr_gnt_d   = do_exec_wr;
      mem_rd_req_d    = grant_fetch | do_exec_rd;
      mem_wr_req_d    = do_exec_wr;
      rd_owner_exec_d = do_exec_rd;

      mem_addr_d    = mem_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      if (grant_fetch) begin
         mem_addr_d = fetch_rd_addr;
      end else if (do_exec_wr) begin
         mem_addr_d    = exec_wr_addr;
         mem_wr_data_d = exec_wr_data;
      end else if (do_exec_rd) begin
         mem_addr_d = exec_rd_addr;
      end

      // Read data is captured at the end of the strobe cycle and steered by the owner tag
      fetch_rd_valid_d = mem_rd_req_q & ~rd_owner_exec_q;
      exec_rd_valid_d  = mem_rd_req_q & rd_owner_exec_q;
      fetch_rd_data_d  = fetch_rd_valid_d ? mem_rd_data : fetch_rd_data_q;
      exec_rd_data_d   = exec_rd_valid_d ? mem_rd_data : exec_rd_data_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= S_IDLE;
         wait_cnt_q       <= '0;
         fetch_rd_gnt_q   <= 1'b0;
         exec_rd_gnt_q    <= 1'b0;
         exec_wr_gnt_q    <= 1'b0;
         mem_rd_req_q     <= 1'b0;
         mem_wr_req_q     <= 1'b0;
         mem_addr_q       <= '0;
         mem_wr_data_q    <= '0;
         rd_owner_exec_q  <= 1'b0;
         fetch_rd_valid_q <= 1'b0;
         fetch_rd_data_q  <= '0;
         exec_rd_valid_q  <= 1'b0;
         exec_rd_data_q   <= '0;
`ifdef PDP_ARB_RR_EN
         last_fetch_q     <= 1'b1;
`endif
      end else begin
         state_q          <= state_d;
         wait_cnt_q       <= wait_cnt_d;
         fetch_rd_gnt_q   <= fetch_rd_gnt_d;
         exec_rd_gnt_q    <= exec_rd_gnt_d;
         exec_wr_gnt_q    <= exec_wr_gnt_d;
         mem_rd_req_q     <= mem_rd_req_d;
         mem_wr_req_q     <= mem_wr_req_d;
         mem_addr_q       <= mem_addr_d;
         mem_wr_data_q    <= mem_wr_data_d;
         rd_owner_exec_q  <= rd_owner_exec_d;
         fetch_rd_valid_q <= fetch_rd_valid_d;
         fetch_rd_data_q  <= fetch_rd_data_d;
         exec_rd_valid_q  <= exec_rd_valid_d;
         exec_rd_data_q   <= exec_rd_data_d;
`ifdef PDP_ARB_RR_EN
         last_fetch_q     <= last_fetch_d;
`endif
      end
   end

   assign fetch_rd_gnt   = fetch_rd_gnt_q;
   assign fetch_rd_valid = fetch_rd_valid_q;
   assign fetch_rd_data  = fetch_rd_data_q;
   assign exec_rd_gnt    = exec_rd_gnt_q;
   assign exec_wr_gnt    = exec_wr_gnt_q;
   assign exec_rd_valid  = exec_rd_valid_q;
   assign exec_rd_data   = exec_rd_data_q;
   assign mem_rd_req     = mem_rd_req_q;
   assign mem_wr_req     = mem_wr_req_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wr_data    = mem_wr_data_q;

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// tb/tb_pdp_mem_arbiter.sv - directed self-checking bench for pdp_mem_arbiter
module tb_pdp_mem_arbiter;
   localparam int AW = 12;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_rd_req;
   logic [AW-1:0] fetch_rd_addr;
   logic          fetch_rd_gnt;
   logic          fetch_rd_valid;
   logic [DW-1:0] fetch_rd_data;
   logic          exec_rd_req;
   logic [AW-1:0] exec_rd_addr;
   logic          exec_wr_req;
   logic [AW-1:0] exec_wr_addr;
   logic [DW-1:0] exec_wr_data;
   logic          exec_lock;
   logic          exec_rd_gnt;
   logic          exec_wr_gnt;
   logic          exec_rd_valid;
   logic [DW-1:0] exec_rd_data;
   logic          mem_rd_req;
   logic          mem_wr_req;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wr_data;
   logic [DW-1:0] mem_rd_data;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pdp_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
      .clk(clk), .reset(reset),
      .fetch_rd_req(fetch_rd_req), .fetch_rd_addr(fetch_rd_addr),
      .fetch_rd_gnt(fetch_rd_gnt), .fetch_rd_valid(fetch_rd_valid), .fetch_rd_data(fetch_rd_data),
      .exec_rd_req(exec_rd_req), .exec_rd_addr(exec_rd_addr),
      .exec_wr_req(exec_wr_req), .exec_wr_addr(exec_wr_addr), .exec_wr_data(exec_wr_data),
      .exec_lock(exec_lock),
      .exec_rd_gnt(exec_rd_gnt), .exec_wr_gnt(exec_wr_gnt),
      .exec_rd_valid(exec_rd_valid), .exec_rd_data(exec_rd_data),
      .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   // Memory model: contents reload on reset, read data follows the presented address
   assign mem_rd_data = mem[mem_addr];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'(i);
         mem[12'o200] <= 12'o1234;
         mem[12'o300] <= 12'o1111;
         mem[12'o301] <= 12'o2222;
         mem[12'o051] <= 12'o3333;
      end else if (mem_wr_req) begin
         mem[mem_addr] <= mem_wr_data;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0o expected %0o", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic exp_fetch_win(input int i);
`ifdef PDP_ARB_RR_EN
      return (i % 2) == 1;
`else
      return (i % 5) == 4;
`endif
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_gnts"}, {29'd0, fetch_rd_gnt, exec_rd_gnt, exec_wr_gnt}, 32'd0);
      check({tag, "_strb"}, {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
      check({tag, "_vld"}, {30'd0, fetch_rd_valid, exec_rd_valid}, 32'd0);
      check({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_wdat"}, 32'(mem_wr_data), 32'd0);
      check({tag, "_fdat"}, 32'(fetch_rd_data), 32'd0);
      check({tag, "_edat"}, 32'(exec_rd_data), 32'd0);
   endtask

   task automatic contention(input string tag, input int n);
      logic ef, prev_f;
      prev_f = 1'b0;
      exec_rd_addr = 12'o300;
      fetch_rd_addr = 12'o301;
      exec_rd_req = 1'b1;
      fetch_rd_req = 1'b1;
      for (int i = 0; i < n; i++) begin
         tick();
         ef = exp_fetch_win(i);
         check({tag, "_fgnt"}, 32'(fetch_rd_gnt), 32'(ef));
         check({tag, "_egnt"}, 32'(exec_rd_gnt), 32'(!ef));
         if (i > 0) begin
            check({tag, "_fvld"}, 32'(fetch_rd_valid), 32'(prev_f));
            check({tag, "_evld"}, 32'(exec_rd_valid), 32'(!prev_f));
            if (prev_f) check({tag, "_fdat"}, 32'(fetch_rd_data), 32'o2222);
            else        check({tag, "_edat"}, 32'(exec_rd_data), 32'o1111);
         end
         prev_f = ef;
      end
      exec_rd_req = 1'b0;
      fetch_rd_req = 1'b0;
      tick();
      check({tag, "_last_fvld"}, 32'(fetch_rd_valid), 32'(prev_f));
      check({tag, "_last_gnt"}, {30'd0, fetch_rd_gnt, exec_rd_gnt}, 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      fetch_rd_req = 1'b1; fetch_rd_addr = '0;
      exec_rd_req = 1'b1;  exec_rd_addr = '0;
      exec_wr_req = 1'b1;  exec_wr_addr = '0; exec_wr_data = '0;
      exec_lock = 1'b0;

      // Reset held 2 cycles with every request high
      tick(); check_all_zero("rst1");
      tick(); check_all_zero("rst2");
      reset = 1'b0;
      tick();
      check("first_wgnt", 32'(exec_wr_gnt), 32'd1);
      check("first_wstrb", 32'(mem_wr_req), 32'd1);
      check("first_fgnt", 32'(fetch_rd_gnt), 32'd0);
      fetch_rd_req = 1'b0; exec_rd_req = 1'b0; exec_wr_req = 1'b0;
      tick();

      // Fetch only
      fetch_rd_addr = 12'o200; fetch_rd_req = 1'b1;
      tick();
      check("f_gnt", 32'(fetch_rd_gnt), 32'd1);
      check("f_rstrb", 32'(mem_rd_req), 32'd1);
      check("f_addr", 32'(mem_addr), 32'o200);
      fetch_rd_req = 1'b0;
      tick();
      check("f_vld", 32'(fetch_rd_valid), 32'd1);
      check("f_dat", 32'(fetch_rd_data), 32'o1234);
      check("f_evld", 32'(exec_rd_valid), 32'd0);
      check("f_gnt_off", 32'(fetch_rd_gnt), 32'd0);

      // Contention
      contention("cont", 10);

      // Locked read-modify-write with fetch pending
      exec_lock = 1'b1; exec_rd_addr = 12'o040; exec_rd_req = 1'b1;
      fetch_rd_addr = 12'o200; fetch_rd_req = 1'b1;
      tick();
      check("lk_rgnt", 32'(exec_rd_gnt), 32'd1);
      check("lk_fgnt0", 32'(fetch_rd_gnt), 32'd0);
      exec_rd_req = 1'b0; exec_wr_req = 1'b1; exec_wr_addr = 12'o040; exec_wr_data = 12'o041;
      tick();
      check("lk_wgnt", 32'(exec_wr_gnt), 32'd1);
      check("lk_fgnt1", 32'(fetch_rd_gnt), 32'd0);
      check("lk_evld", 32'(exec_rd_valid), 32'd1);
      check("lk_edat", 32'(exec_rd_data), 32'o040);
      check("lk_waddr", 32'(mem_addr), 32'o040);
      check("lk_wdat", 32'(mem_wr_data), 32'o041);
      exec_wr_req = 1'b0;
      tick(); check("lk_fgnt2", 32'(fetch_rd_gnt), 32'd0);
      tick(); check("lk_fgnt3", 32'(fetch_rd_gnt), 32'd0);
      exec_lock = 1'b0;
      tick();
      check("unlk_fgnt", 32'(fetch_rd_gnt), 32'd1);
      check("unlk_addr", 32'(mem_addr), 32'o200);
      fetch_rd_req = 1'b0;
      tick();
      check("unlk_fvld", 32'(fetch_rd_valid), 32'd1);
      check("unlk_fdat", 32'(fetch_rd_data), 32'o1234);

      // EXEC read and write requested together
      exec_wr_req = 1'b1; exec_wr_addr = 12'o050; exec_wr_data = 12'o7777;
      exec_rd_req = 1'b1; exec_rd_addr = 12'o051;
      tick();
      check("rw_wgnt", 32'(exec_wr_gnt), 32'd1);
      check("rw_rgnt0", 32'(exec_rd_gnt), 32'd0);
      check("rw_wdat", 32'(mem_wr_data), 32'o7777);
      exec_wr_req = 1'b0;
      tick();
      check("rw_rgnt1", 32'(exec_rd_gnt), 32'd1);
      check("rw_wgnt1", 32'(exec_wr_gnt), 32'd0);
      check("rw_raddr", 32'(mem_addr), 32'o051);
      check("rw_wdat_hold", 32'(mem_wr_data), 32'o7777);
      exec_rd_req = 1'b0;
      tick();
      check("rw_evld", 32'(exec_rd_valid), 32'd1);
      check("rw_edat", 32'(exec_rd_data), 32'o3333);

      // Reset while a read is in flight
      fetch_rd_addr = 12'o200; fetch_rd_req = 1'b1;
      tick();
      check("rif_rstrb", 32'(mem_rd_req), 32'd1);
      reset = 1'b1; fetch_rd_req = 1'b0;
      tick();
      check("rif_vld1", 32'(fetch_rd_valid), 32'd0);
      check("rif_strb1", 32'(mem_rd_req), 32'd0);
      reset = 1'b0;
      tick();
      check("rif_vld2", 32'(fetch_rd_valid), 32'd0);
      contention("post_rst", 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
